// File: rtl/johnson_pkg.sv
// ---------------------------------------------------------------------------
// johnson_pkg
// Shared types and helper functions for the Johnson phase decoder.
//   state_e          : lock/error state machine encoding
//   johnson_succ     : legal successor of a Johnson code
//   johnson_is_legal : code is one of the 2*width legal Johnson codes
//   johnson_idx      : phase index of a legal Johnson code
// The helpers take a zero-extended 32-bit code plus its real width so that
// they serve any WIDTH parameter of the modules that import them.
// ---------------------------------------------------------------------------
package johnson_pkg;

    localparam int unsigned JOHNSON_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACQ,
        ST_LOCK,
        ST_ERR
    } state_e;

    // Shift right by one, feeding the inverted LSB into the MSB.
    function automatic logic [31:0] johnson_succ(input logic [31:0] code,
                                                 input int unsigned width);
        logic [31:0] mask;
        mask = (32'd1 << width) - 32'd1;
        return ((code >> 1) | ({31'd0, ~code[0]} << (width - 1))) & mask;
    endfunction

    // A legal Johnson code is a single run of ones and a single run of zeros,
    // i.e. at most one transition between neighbouring bits.
    function automatic logic johnson_is_legal(input logic [31:0] code,
                                              input int unsigned width);
        int unsigned edges;
        edges = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((i + 1 < width) && (code[i] != code[i+1])) begin
                edges++;
            end
        end
        return (edges <= 1);
    endfunction

    // Filling phase (MSB set, or all zeros): index equals the number of ones.
    // Draining phase (MSB clear): index counts down from 2*width.
    function automatic logic [31:0] johnson_idx(input logic [31:0] code,
                                                input int unsigned width);
        int unsigned ones;
        ones = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((i < width) && code[i]) begin
                ones++;
            end
        end
        if ((code == '0) || code[width-1]) begin
            return ones;
        end
        return 2 * width - ones;
    endfunction

endpackage

// File: rtl/johnson_phase_decoder_decode.sv
// ---------------------------------------------------------------------------
// johnson_code_decode
// Purely combinational decode of one Johnson code sample.
//   code_i   : Johnson code, MSB first
//   valid_o  : code is legal
//   idx_o    : binary phase index, 0 when illegal
//   onehot_o : one-hot phase, all zeros when illegal
// ---------------------------------------------------------------------------
module johnson_code_decode
    import johnson_pkg::*;
#(
    parameter  int unsigned WIDTH  = JOHNSON_WIDTH,
    localparam int unsigned PHASES = 2 * WIDTH,
    localparam int unsigned IDX_W  = $clog2(PHASES)
) (
    input  logic [WIDTH-1:0]  code_i,
    output logic              valid_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic [PHASES-1:0] onehot_o
);

    logic [31:0] code_ext;

    assign code_ext = 32'(code_i);

    // NOTE: every output gets a default before the conditional, so no latch.
    always_comb begin
        valid_o  = johnson_is_legal(code_ext, WIDTH);
        idx_o    = '0;
        onehot_o = '0;
        if (valid_o) begin
            idx_o    = IDX_W'(johnson_idx(code_ext, WIDTH));
            onehot_o = PHASES'(1) << idx_o;
        end
    end

endmodule

// File: rtl/johnson_phase_decoder.sv
// ---------------------------------------------------------------------------
// johnson_phase_decoder
// Registers the raw Johnson code, decodes it to a phase, checks each step
// against the legal successor and runs an IDLE/ACQ/LOCK/ERR state machine.
//   clk          : single clock, rising edge
//   rst          : asynchronous active-low reset
//   code_in      : Johnson code from the counter (synchronous to clk)
//   clr_err      : synchronous clear of the error state and revolution count
//   phase_onehot : one-hot phase of the registered sample, 0 if illegal
//   phase_idx    : binary phase index, 0 if illegal
//   valid_code   : registered sample is legal
//   locked       : state machine is in LOCK
//   err          : state machine is in ERR (sticky until clr_err)
//   rev_count    : full revolutions completed while locked
// Build option: define JOHNSON_DEC_REV_CNT_EN to build the revolution
// counter; otherwise rev_count is tied to zero.
// ---------------------------------------------------------------------------
module johnson_phase_decoder
    import johnson_pkg::*;
#(
    parameter  int unsigned WIDTH    = JOHNSON_WIDTH,
    parameter  int unsigned LOCK_CNT = 2,
    parameter  int unsigned REV_W    = 8,
    localparam int unsigned PHASES   = 2 * WIDTH,
    localparam int unsigned IDX_W    = $clog2(PHASES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  code_in,
    input  logic              clr_err,
    output logic [PHASES-1:0] phase_onehot,
    output logic [IDX_W-1:0]  phase_idx,
    output logic              valid_code,
    output logic              locked,
    output logic              err,
    output logic [REV_W-1:0]  rev_count
);

    localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);

    logic [WIDTH-1:0]  code_q;
    logic [WIDTH-1:0]  code_p;
    logic              smp_q;     // code_q holds a real sample (not reset value)
    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;

    logic              dec_valid;
    logic [IDX_W-1:0]  dec_idx;
    logic [PHASES-1:0] dec_onehot;
    logic              cur_legal;
    logic              is_step;
    logic              is_hold;
    logic              is_viol;

    johnson_code_decode #(.WIDTH(WIDTH)) u_decode (
        .code_i   (code_q),
        .valid_o  (dec_valid),
        .idx_o    (dec_idx),
        .onehot_o (dec_onehot)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            code_q <= '0;
            code_p <= '0;
            smp_q  <= 1'b0;
        end else begin
            code_q <= code_in;
            code_p <= code_q;
            smp_q  <= 1'b1;
        end
    end

    // Step and hold both require a legal current sample. Comparisons are only
    // acted on in ACQ/LOCK, which are reachable only after a real sample has
    // moved into code_p, so the first post-reset sample is never compared.
    assign cur_legal = smp_q && dec_valid;
    assign is_step   = cur_legal && (code_q == WIDTH'(johnson_succ(32'(code_p), WIDTH)));
    assign is_hold   = cur_legal && (code_q == code_p);
    assign is_viol   = !(is_step || is_hold);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cur_legal) begin
                    state_d = ST_ACQ;
                    cnt_d   = '0;
                end
            end
            ST_ACQ: begin
                if (is_step) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q + 4'd1 == LOCK_TGT) begin
                        state_d = ST_LOCK;
                    end
                end else if (is_viol) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_LOCK: begin
                if (is_viol) begin
                    state_d = ST_ERR;
                end
            end
            ST_ERR: begin
                // clr_err takes precedence over whatever the code does.
                if (clr_err) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // Outputs: decode is blanked until the first real sample is registered.
    always_comb begin
        valid_code   = smp_q && dec_valid;
        phase_idx    = smp_q ? dec_idx : '0;
        phase_onehot = smp_q ? dec_onehot : '0;
        locked       = (state_q == ST_LOCK);
        err          = (state_q == ST_ERR);
    end

`ifdef JOHNSON_DEC_REV_CNT_EN
    logic [REV_W-1:0] rev_q, rev_d;

    // The only legal step into phase 0 comes from the last phase, so a step
    // landing on the all-zeros code marks a completed revolution.
    always_comb begin
        rev_d = rev_q;
        if (clr_err) begin
            rev_d = '0;
        end else if ((state_q == ST_LOCK) && is_step && (code_q == '0)) begin
            rev_d = rev_q + REV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rev_q <= '0;
        end else begin
            rev_q <= rev_d;
        end
    end

    assign rev_count = rev_q;
`else
    assign rev_count = '0;
`endif

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// ---------------------------------------------------------------------------
// tb_johnson_phase_decoder
// Self-checking bench for johnson_phase_decoder (WIDTH=4, LOCK_CNT=2,
// REV_W=2). A phase-table model predicts every output each cycle; directed
// literal checks pin the model at the interesting points.
// ---------------------------------------------------------------------------
module tb_johnson_phase_decoder;

`ifdef JOHNSON_DEC_REV_CNT_EN
    localparam bit REV_EN = 1'b1;
`else
    localparam bit REV_EN = 1'b0;
`endif

    localparam int REV_MOD = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] code_in;
    logic       clr_err;
    logic [7:0] phase_onehot;
    logic [2:0] phase_idx;
    logic       valid_code;
    logic       locked;
    logic       err;
    logic [1:0] rev_count;

    int checks   = 0;
    int failures = 0;
    bit run_cmp  = 1'b0;

    johnson_phase_decoder #(.WIDTH(4), .LOCK_CNT(2), .REV_W(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .code_in      (code_in),
        .clr_err      (clr_err),
        .phase_onehot (phase_onehot),
        .phase_idx    (phase_idx),
        .valid_code   (valid_code),
        .locked       (locked),
        .err          (err),
        .rev_count    (rev_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int seq_tab [8] = '{0, 8, 12, 14, 15, 7, 3, 1};

    function automatic int phase_of(input int c);
        for (int i = 0; i < 8; i++) begin
            if (seq_tab[i] == c) return i;
        end
        return -1;
    endfunction

    // mode: 0 idle, 1 acquiring, 2 locked, 3 error
    bit m_have;
    int m_cur, m_prev, m_mode, m_steps, m_rev;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_have = 1'b0; m_cur = 0; m_prev = 0;
            m_mode = 0; m_steps = 0; m_rev = 0;
        end else begin
            int  pc, pp;
            bit  adv, hold;
            pc   = m_have ? phase_of(m_cur) : -1;
            pp   = phase_of(m_prev);
            adv  = (pc >= 0) && (pp >= 0) && (pc == (pp + 1) % 8);
            hold = (pc >= 0) && (m_cur == m_prev);
            if (REV_EN && m_mode == 2 && adv && pc == 0) m_rev = (m_rev + 1) % REV_MOD;
            case (m_mode)
                0: if (pc >= 0) begin m_mode = 1; m_steps = 0; end
                1: begin
                    if (adv) begin
                        m_steps++;
                        if (m_steps == 2) m_mode = 2;
                    end else if (!hold) begin
                        m_mode = 0; m_steps = 0;
                    end
                end
                2: if (!(adv || hold)) m_mode = 3;
                default: if (clr_err) m_mode = 0;
            endcase
            if (clr_err) m_rev = 0;
            m_prev = m_cur;
            m_cur  = int'(code_in);
            m_have = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (run_cmp) begin
            int  p;
            bit  ev;
            p  = m_have ? phase_of(m_cur) : -1;
            ev = (p >= 0);
            check("cmp_valid",  32'(valid_code),   32'(ev));
            check("cmp_idx",    32'(phase_idx),    ev ? p : 0);
            check("cmp_onehot", 32'(phase_onehot), ev ? (32'd1 << p) : 32'd0);
            check("cmp_locked", 32'(locked),       32'(m_mode == 2));
            check("cmp_err",    32'(err),          32'(m_mode == 3));
            check("cmp_rev",    32'(rev_count),    m_rev);
        end
    end

    // ---------------- directed stimulus ----------------
    // Entered and left on a falling edge; the sample is taken on the rising
    // edge in between.
    task automatic step(input logic [3:0] c);
        code_in = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic acquire();
        step(4'h0);
        check("acq_valid0",  32'(valid_code),   1);
        check("acq_onehot0", 32'(phase_onehot), 32'h01);
        check("acq_lock0",   32'(locked),       0);
        step(4'h8);
        check("acq_idx8",    32'(phase_idx),    1);
        step(4'hC);
        check("acq_lock_c",  32'(locked),       0);
        step(4'hE);
        check("acq_locked",  32'(locked),       1);
        check("acq_err",     32'(err),          0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] rev_seq [8] = '{4'hF, 4'h7, 4'h3, 4'h1, 4'h0, 4'h8, 4'hC, 4'hE};
        rst = 1'b0; code_in = 4'h0; clr_err = 1'b0;
        #1 run_cmp = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_onehot", 32'(phase_onehot), 0);
        check("rst_valid",  32'(valid_code),   0);
        check("rst_rev",    32'(rev_count),    0);
        rst = 1'b1;

        // Lock from the free-running sequence, then one wrap while locked.
        acquire();
        step(4'hF); step(4'h7); step(4'h3); step(4'h1); step(4'h0);
        step(4'h8);
        check("wrap1_rev", 32'(rev_count), REV_EN ? 1 : 0);
        step(4'hC); step(4'hE);

        // Hold at 1110 while locked.
        for (int i = 0; i < 5; i++) begin
            step(4'hE);
            check("hold_locked", 32'(locked),       1);
            check("hold_idx",    32'(phase_idx),    3);
            check("hold_onehot", 32'(phase_onehot), 32'h08);
        end

        // Skip 0111: 1111 -> 0011 drives LOCK into ERR.
        step(4'hF);
        step(4'h3);
        check("skip_onehot", 32'(phase_onehot), 32'h40);
        check("skip_locked", 32'(locked),       1);
        step(4'h1);
        check("err_set",     32'(err),          1);
        check("err_unlock",  32'(locked),       0);
        step(4'h0); step(4'h8);
        check("err_sticky",  32'(err),          1);
        clr_err = 1'b1;
        step(4'hC);
        clr_err = 1'b0;
        check("clr_err",     32'(err),          0);
        check("clr_locked",  32'(locked),       0);
        check("clr_rev",     32'(rev_count),    0);

        // Illegal 1010 while acquiring.
        step(4'hE);
        step(4'hA);
        check("ill_valid",   32'(valid_code),   0);
        check("ill_onehot",  32'(phase_onehot), 0);
        check("ill_idx",     32'(phase_idx),    0);
        step(4'h0);
        check("ill_err",     32'(err),          0);
        check("ill_locked",  32'(locked),       0);

        // Reacquire, then five full revolutions.
        step(4'h8); step(4'hC); step(4'hE);
        check("rev_locked",  32'(locked),       1);
        check("rev_start",   32'(rev_count),    0);
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 8; k++) begin
                step(rev_seq[k]);
                if (k == 5) check("rev_count", 32'(rev_count), REV_EN ? (r + 1) % REV_MOD : 0);
            end
        end

        // Asynchronous reset mid-revolution.
        step(4'hF); step(4'h7);
        #2 rst = 1'b0;
        #1;
        check("arst_onehot", 32'(phase_onehot), 0);
        check("arst_idx",    32'(phase_idx),    0);
        check("arst_valid",  32'(valid_code),   0);
        check("arst_locked", 32'(locked),       0);
        check("arst_err",    32'(err),          0);
        check("arst_rev",    32'(rev_count),    0);
        @(negedge clk);
        rst = 1'b1;
        acquire();

        run_cmp = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/johnson_phase_decoder.md
# johnson_phase_decoder

Downstream consumer of the 4-bit Johnson ring counter in the same clock domain. Registers the raw Johnson code and decodes it to a one-hot phase and a binary phase index. Checks every step against the legal Johnson successor and runs a lock/error state machine. Optionally counts full revolutions of the sequence.

## Interface
- WIDTH, 4, Johnson code width; the sequence has 2*WIDTH phases.
- LOCK_CNT, 2, consecutive legal advancing steps required to declare lock; range 1..15.
- REV_W, 8, revolution counter width.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous and active-low; clears all state.
- code_in  input  WIDTH  Johnson code from the counter, {q3,q2,q1,q0} ordering, MSB first.
- clr_err  input  1  synchronous clear of the sticky error and revolution count.
- phase_onehot  output  2*WIDTH  one-hot phase of the registered sample; all zeros if illegal.
- phase_idx  output  $clog2(2*WIDTH)  binary phase index; 0 if illegal.
- valid_code  output  1  registered sample is a legal Johnson code.
- locked  output  1  high in LOCK state only.
- err  output  1  sticky sequence-violation flag; high in ERR state only.
- rev_count  output  REV_W  completed revolutions while locked.

## Operation
- **Legal codes and phase index:**
  - Legal codes are the 2*WIDTH values 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001 (WIDTH=4), with phase index 0..7 in that order.
  - Index rule: if code==0 or the MSB is 1, idx = popcount; otherwise idx = 2*WIDTH − popcount.
  - Any other code is illegal.
- **Successor rule:** succ(c) = {~c[0], c[WIDTH-1:1]}. Each cycle compares the current sample code_q against the previous sample code_p:
  - step: code_q == succ(code_p).
  - hold: code_q == code_p, and code_q is legal.
  - violation: anything else, including any illegal code.
- **State machine:**
  - IDLE:
    - legal sample → ACQ with step count 0.
    - illegal sample → stay in IDLE.
  - ACQ:
    - step → count+1; when count reaches LOCK_CNT → LOCK.
    - hold → no change.
    - violation → IDLE with count 0. err is not set.
  - LOCK:
    - step or hold → stay in LOCK.
    - violation → ERR.
  - ERR:
    - stays in ERR regardless of code_in.
    - clr_err → IDLE.
- **Clear precedence:** clr_err in any state clears rev_count. clr_err in ERR wins over a simultaneous violation. clr_err in IDLE, ACQ or LOCK does not change state.
- **Revolutions:** in LOCK, a step from phase 2*WIDTH−1 to phase 0 increments rev_count.
  - Wraps modulo 2^REV_W.
  - Held in ACQ and ERR; not cleared on entering IDLE.
  - Cleared only by reset or clr_err.
- **Reset mid-operation:** asynchronous return to IDLE.
  - code_q, code_p, count, rev_count and all outputs go to 0.
  - The first post-reset sample is never compared.

## Timing
- code_in sampled into code_q at edge k.
- phase_onehot, phase_idx and valid_code reflect that sample after edge k: decoded combinationally from code_q, so 1-cycle latency.
- code_p <= code_q on every edge. The step/hold/violation decision for the sample taken at edge k takes effect at edge k+1, so locked and err have 2-cycle latency from code_in.
- rev_count updates on the same edge as the state machine.
- Reset values: phase_onehot=0, phase_idx=0, valid_code=0, locked=0, err=0, rev_count=0.
- code_in must be synchronous to clk; no synchronizer is provided.

## Configuration
- JOHNSON_DEC_REV_CNT_EN defined: the revolution counter logic is built as described.
- JOHNSON_DEC_REV_CNT_EN not defined: rev_count is tied to 0 and no counter flops are built. All other behaviour is identical.

## Structure
- **Package johnson_pkg:**
  - state enum (IDLE, ACQ, LOCK, ERR)
  - function johnson_succ
  - function johnson_is_legal
  - function johnson_idx
  - default WIDTH constant
- **Sub-module johnson_code_decode:** purely combinational code → {valid, idx, onehot}. Instantiated once on code_q. The top holds the registers, the state machine and rev_count.

## Test plan
- Reset release, then feed the free-running counter sequence 0000, 1000, 1100, 1110… (LOCK_CNT=2) → valid_code=1 from the first sample; locked=1 two cycles after the third sample (1100); err=0.
- While locked, hold code_in at 1110 for 5 cycles → locked stays 1, phase_idx=3, phase_onehot=8'b0000_1000.
- While locked, jump 1110 → 1111 → 0011 (skip) → ERR two cycles after 0011: err=1, locked=0. phase_onehot=8'b0100_0000 for 0011. err stays 1 through further legal codes until clr_err=1, which returns to IDLE.
- Inject illegal 1010 in ACQ → valid_code=0, phase_onehot=0, return to IDLE, err stays 0.
- With REV_W=2 and the macro defined, run 5 full revolutions locked → rev_count = 0,1,2,3,0,1, incrementing on each 0001→0000 step. With the macro undefined → rev_count=0 throughout.
- Assert rst mid-revolution → all outputs 0 immediately. After release, lock is reacquired per the first scenario.
